bit_plane_serializer: RTL and testbench
=======================================

Name: bit_plane_serializer

Overview:
- Producer end of the bit-plane datapath in the DP_1x64 engine.
- Accepts a vector of M signed two's-complement operands (N bits each) and transposes them into N bit-planes of M bits.
- Emits planes MSB (sign plane) first, one per accepted handshake, each with a sign-plane flag. The flag drives the sign-select input of the downstream popcount adder.
- Downstream accumulates as acc = (acc << 1) + signed_popcount.

Parameters:
- M, 16, number of lanes (operands per vector, plane width)
- N, 8, operand bit width (planes per vector); N >= 2

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- load_valid  input  1  operand vector available
- load_ready  output  1  serializer can accept a vector this cycle
- load_data  input  M*N  lane k at bits [k*N +: N], two's complement
- plane_valid  output  1  plane_bits/plane_msb/plane_idx/plane_last valid
- plane_ready  input  1  downstream accepts the current plane
- plane_bits  output  M  bit plane_idx of every lane; bit k = lane k
- plane_msb  output  1  1 when the current plane is the sign plane (idx N-1)
- plane_idx  output  $clog2(N)  bit position of the current plane
- plane_last  output  1  final plane of the current vector
- busy  output  1  vector held, planes outstanding

Behaviour:
- Reset, asynchronous and active-high. All outputs are 0 except load_ready = 1. FSM goes to IDLE and the operand register clears.
- Reset mid-vector discards the remaining planes. No plane is emitted after reset until a new load.
- FSM states:
  - IDLE: plane_valid=0, load_ready=1. On load_valid, latch load_data, set idx=N-1, go to EMIT.
  - EMIT: plane_valid=1, plane_bits[k] = reg[k*N+idx], plane_msb = (idx==N-1), plane_last = (idx==0).
- EMIT transitions:
  - On plane_ready and not last: idx decrements.
  - On plane_ready and last: go to IDLE, unless a load is accepted in the same cycle.
- Back-to-back loads: load_ready = IDLE OR (EMIT AND plane_last AND plane_ready). A simultaneous last-plane accept and load gives idx=N-1 with no bubble cycle.
- Latency: the first plane is valid the cycle after the load handshake. A vector occupies exactly N plane handshakes.
- Stall: while plane_valid && !plane_ready, all plane_* outputs hold stable.
- load_valid is ignored while load_ready=0. The producer must hold its data until the handshake completes.
- busy = (state==EMIT).
- Widths: plane_idx is $clog2(N) bits. idx never wraps, because last forces the exit.

Optional Feature:
- Macro: BPS_ZERO_PLANE_SKIP_EN.
- When defined:
  - At load, compute nz[i] = |plane_i for i < N-1. The sign plane is always emitted.
  - After each accept, idx jumps to the highest j < idx with nz[j]=1.
  - plane_last = 1 when no nz[j] is set for j < idx.
  - plane_idx carries the true bit weight. Downstream shifts by the idx difference.
  - A vector takes 1..N handshakes.
- When undefined: exactly N planes, and nz logic is absent.

Decomposition:
- Package bps_pkg holds:
  - state enum (IDLE, EMIT)
  - localparam IDX_W = $clog2(N)
  - a function plane_of(data, idx) returning the M-bit plane
- Natural sub-module: bps_next_idx, a priority encoder finding the highest set nz bit below idx. It is instantiated only under BPS_ZERO_PLANE_SKIP_EN.

Test Plan:
Bench overrides M=4, N=4. Lanes are listed lane0..lane3.
- Reset: assert rst mid-vector after 2 planes -> plane_valid=0 and load_ready=1 immediately. No further planes after release.
- Basic: load lanes {3,-1,5,-8}, plane_ready=1 -> plane_bits (lane0 at bit 0):
  - idx3 = 4'b1010, msb=1
  - idx2 = 4'b0110
  - idx1 = 4'b0011
  - idx0 = 4'b0111, last=1
  - exactly 4 cycles.
- Stall: same vector, plane_ready low for 3 cycles at idx2 -> plane_bits=4'b0110 and idx=2 held stable; the sequence resumes unchanged.
- Back-to-back: second load_valid held during the first vector -> load_ready pulses only with the last-plane accept. The second vector's idx3 appears the next cycle with no gap; 8 planes in 8 cycles.
- Downstream check: reconstruct lanes with acc = (acc<<1) + (msb ? -pop : pop) weighted per lane -> 200 random vectors match the input operands bit-exactly.
- Skip (BPS_ZERO_PLANE_SKIP_EN): load {1,1,1,1} -> planes idx3 (4'b0000, msb=1) then idx0 (4'b1111, last=1), 2 handshakes total.

Source files
------------

// File: rtl/bps_pkg.sv
// rtl/bps_pkg.sv - shared types, widths and plane extraction for the bit-plane serializer
package bps_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int M_DEFAULT = 16;
    localparam int N_DEFAULT = 8;
    localparam int IDX_W     = $clog2(N_DEFAULT);

    // Widest lane count / operand width the extraction helper handles.
    localparam int MAX_M    = 64;
    localparam int MAX_N    = 16;
    localparam int MAX_BITS = MAX_M * MAX_N;
    localparam int MAX_AW   = $clog2(MAX_BITS);

    function automatic logic [MAX_M-1:0] plane_of(input logic [MAX_BITS-1:0] data,
                                                  input int n, input int idx);
        logic [MAX_M-1:0] p;
        p = '0;
        for (int k = 0; k < MAX_M; k++) begin
            p[k] = data[MAX_AW'(k * n + idx)];
        end
        return p;
    endfunction

endpackage

// File: rtl/bit_plane_serializer_next_idx.sv
// rtl/bit_plane_serializer_next_idx.sv - highest non-zero plane below idx; built only with BPS_ZERO_PLANE_SKIP_EN
`ifdef BPS_ZERO_PLANE_SKIP_EN
module bps_next_idx
    import bps_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]         nz,
    input  logic [$clog2(N)-1:0] idx,
    output logic                 found,
    output logic [$clog2(N)-1:0] next_idx
);
    localparam int IW = $clog2(N);

    // Ascending scan so the highest qualifying plane wins.
    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        for (int j = 0; j < N; j++) begin
            if (j < int'(idx) && nz[j]) begin
                found    = 1'b1;
                next_idx = IW'(j);
            end
        end
    end

endmodule
`endif

// File: rtl/bit_plane_serializer.sv
// rtl/bit_plane_serializer.sv - transposes M signed N-bit lanes into N bit-planes, sign plane first
// Optional zero-plane skipping is enabled by defining BPS_ZERO_PLANE_SKIP_EN.
module bit_plane_serializer
    import bps_pkg::*;
#(
    parameter int M = 16,
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [M*N-1:0]       load_data,
    output logic                 plane_valid,
    input  logic                 plane_ready,
    output logic [M-1:0]         plane_bits,
    output logic                 plane_msb,
    output logic [$clog2(N)-1:0] plane_idx,
    output logic                 plane_last,
    output logic                 busy
);
    localparam int IW = $clog2(N);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [M*N-1:0]  data_q, data_d;
    logic [IW-1:0]   idx_next;
    logic            last;
    logic            load_fire;
    logic            plane_fire;
    logic [MAX_BITS-1:0] data_ext;

    always_comb begin
        data_ext            = '0;
        data_ext[M*N-1:0]   = data_q;
    end

`ifdef BPS_ZERO_PLANE_SKIP_EN
    logic [N-1:0]        nz_q, nz_d, nz_load;
    logic [MAX_BITS-1:0] load_ext;
    logic                found;

    // Sign plane is always emitted, so its nz bit stays clear.
    always_comb begin
        load_ext          = '0;
        load_ext[M*N-1:0] = load_data;
        nz_load           = '0;
        for (int i = 0; i < N - 1; i++) begin
            nz_load[i] = |(M'(plane_of(load_ext, N, i)));
        end
    end

    always_comb begin
        nz_d = nz_q;
        if (load_fire) begin
            nz_d = nz_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nz_q <= '0;
        end else begin
            nz_q <= nz_d;
        end
    end

    bps_next_idx #(.N(N)) u_next_idx (
        .nz       (nz_q),
        .idx      (idx_q),
        .found    (found),
        .next_idx (idx_next)
    );

    assign last = !found;
`else
    assign idx_next = idx_q - 1'b1;
    assign last     = (idx_q == '0);
`endif

    assign load_ready = (state_q == IDLE) || ((state_q == EMIT) && last && plane_ready);
    assign load_fire  = load_valid && load_ready;
    assign plane_fire = (state_q == EMIT) && plane_ready;

    // A load accepted alongside the last plane takes priority, giving no bubble.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (load_fire) begin
            state_d = EMIT;
            idx_d   = IW'(N - 1);
            data_d  = load_data;
        end else if (plane_fire) begin
            if (last) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        plane_valid = (state_q == EMIT);
        plane_bits  = '0;
        if (plane_valid) begin
            plane_bits = M'(plane_of(data_ext, N, int'(idx_q)));
        end
        plane_msb  = plane_valid && (idx_q == IW'(N - 1));
        plane_last = plane_valid && last;
        plane_idx  = idx_q;
        busy       = plane_valid;
    end

endmodule

// File: tb/tb_bit_plane_serializer.sv
// tb/tb_bit_plane_serializer.sv - table-driven and scoreboard bench for bit_plane_serializer (M=4, N=4)
module tb_bit_plane_serializer;
    localparam int M = 4;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        plane_valid;
    logic        plane_ready;
    logic [3:0]  plane_bits;
    logic        plane_msb;
    logic [1:0]  plane_idx;
    logic        plane_last;
    logic        busy;

    always #5 clk = ~clk;

    bit_plane_serializer #(.M(M), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .plane_valid (plane_valid),
        .plane_ready (plane_ready),
        .plane_bits  (plane_bits),
        .plane_msb   (plane_msb),
        .plane_idx   (plane_idx),
        .plane_last  (plane_last),
        .busy        (busy)
    );

    typedef struct {
        logic [3:0] bits;
        logic [1:0] idx;
        logic       msb;
        logic       last;
    } plane_t;

    typedef struct {
        logic [15:0]      data;
        logic [3:0][3:0]  pl;
    } vec_t;

    plane_t      planeq[$];
    logic [15:0] opq[$];
    int          tests = 0;
    int          fails = 0;
    int          vcyc = 0;
    int          acc_cnt = 0;
    bit          check_planes = 1'b1;
    int          acc[4];
    int          prev_idx = 0;
    plane_t      mon_e;
    logic [15:0] mon_op;
    int          mon_bad;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] pack(input int l0, input int l1, input int l2, input int l3);
        return {4'(l3), 4'(l2), 4'(l1), 4'(l0)};
    endfunction

    function automatic int lane_val(input logic [15:0] v, input int k);
        logic [3:0] l;
        l = v[k*4 +: 4];
        return int'($signed(l));
    endfunction

    // Monitor: plane scoreboard plus downstream-style lane reconstruction.
    always @(negedge clk) begin
        if (plane_valid) vcyc++;
        if (!rst && plane_valid && plane_ready) begin
            acc_cnt++;
            if (check_planes) begin
                if (planeq.size() == 0) begin
                    check("unexpected_plane", 32'(plane_idx), 32'hffff_ffff);
                end else begin
                    mon_e = planeq.pop_front();
                    check("plane", {24'd0, plane_bits, plane_idx, plane_msb, plane_last},
                          {24'd0, mon_e.bits, mon_e.idx, mon_e.msb, mon_e.last});
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (plane_msb) acc[k] = -int'(plane_bits[k]);
                else acc[k] = (acc[k] <<< (prev_idx - int'(plane_idx))) + int'(plane_bits[k]);
            end
            prev_idx = int'(plane_idx);
            if (plane_last) begin
                if (opq.size() == 0) begin
                    check("recon_no_operand", 32'd1, 32'd0);
                end else begin
                    mon_op  = opq.pop_front();
                    mon_bad = 0;
                    for (int k = 0; k < 4; k++) begin
                        if ((acc[k] <<< int'(plane_idx)) != lane_val(mon_op, k)) mon_bad++;
                    end
                    check("recon_lanes", 32'(mon_bad), 32'd0);
                end
            end
        end
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0][3:0] pl, input bit push,
                           input bit rnd, output int waits);
        bit got;
        got        = 1'b0;
        waits      = 0;
        load_data  = d;
        load_valid = 1'b1;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            if (load_ready) begin
                got = 1'b1;
                opq.push_back(d);
                if (push) begin
                    for (int i = 3; i >= 0; i--) begin
                        planeq.push_back('{pl[i], 2'(i), (i == 3), (i == 0)});
                    end
                end
            end else begin
                waits++;
                @(posedge clk); #1;
                if (rnd) plane_ready = ($urandom % 4) != 0;
            end
        end
        if (!got) check("load_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain(input bit rnd);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (opq.size() == 0 && !plane_valid) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (rnd) plane_ready = ($urandom % 4) != 0;
            end
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        plane_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    vec_t        tbl[3];
    int          w;
    logic [31:0] rv;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0].data = pack(3, -1, 5, -8);
        tbl[0].pl   = {4'b1010, 4'b0110, 4'b0011, 4'b0111};
        tbl[1].data = pack(7, -8, 1, -2);
        tbl[1].pl   = {4'b1010, 4'b1001, 4'b1001, 4'b0101};
        tbl[2].data = pack(-1, 0, -1, 0);
        tbl[2].pl   = {4'b0101, 4'b0101, 4'b0101, 4'b0101};

        rst         = 1'b1;
        load_valid  = 1'b0;
        load_data   = '0;
        plane_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {22'd0, load_ready, plane_valid, busy, plane_bits, plane_msb, plane_idx, plane_last},
              {22'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b0});
        @(posedge clk); #1;
        rst = 1'b0;

        // Table vectors, full-rate downstream: exactly four plane cycles each.
        for (int i = 0; i < 3; i++) begin
            vcyc = 0;
            do_load(tbl[i].data, tbl[i].pl, 1'b1, 1'b0, w);
            load_valid = 1'b0;
            drain(1'b0);
            check("plane_cycles", 32'(vcyc), 32'd4);
        end

        // Stall at idx2 for three cycles.
        plane_ready = 1'b0;
        do_load(tbl[0].data, tbl[0].pl, 1'b1, 1'b0, w);
        load_valid  = 1'b0;
        plane_ready = 1'b1;
        @(posedge clk); #1;
        plane_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_hold", {26'd0, plane_valid, plane_bits, plane_idx}, {26'd0, 1'b1, 4'b0110, 2'd2});
        end
        @(posedge clk); #1;
        plane_ready = 1'b1;
        drain(1'b0);

        // Back-to-back: second load waits for the last-plane accept, no bubble.
        vcyc = 0;
        do_load(tbl[1].data, tbl[1].pl, 1'b1, 1'b0, w);
        do_load(tbl[0].data, tbl[0].pl, 1'b1, 1'b0, w);
        load_valid = 1'b0;
        check("b2b_ready_wait", 32'(w), 32'd3);
        @(negedge clk);
        check("b2b_no_gap", {29'd0, plane_valid, plane_idx}, {29'd0, 1'b1, 2'd3});
        drain(1'b0);
        check("b2b_cycles", 32'(vcyc), 32'd8);

        // Reset after two planes accepted.
        acc_cnt = 0;
        do_load(tbl[0].data, tbl[0].pl, 1'b1, 1'b0, w);
        load_valid = 1'b0;
        for (int t = 0; t < 20 && acc_cnt < 2; t++) @(negedge clk);
        check("reset_plane_count", 32'(acc_cnt), 32'd2);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("reset_mid", {29'd0, plane_valid, load_ready, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
        planeq.delete();
        opq.delete();
        @(posedge clk); #1;
        rst  = 1'b0;
        vcyc = 0;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        check("no_plane_after_reset", 32'(vcyc), 32'd0);

`ifdef BPS_ZERO_PLANE_SKIP_EN
        vcyc = 0;
        planeq.push_back('{4'b0000, 2'd3, 1'b1, 1'b0});
        planeq.push_back('{4'b1111, 2'd0, 1'b0, 1'b1});
        do_load(pack(1, 1, 1, 1), '0, 1'b0, 1'b0, w);
        load_valid = 1'b0;
        drain(1'b0);
        check("skip_cycles", 32'(vcyc), 32'd2);
`endif

        // Random vectors with random downstream backpressure; lanes rebuilt downstream-style.
        check_planes = 1'b0;
        for (int i = 0; i < 200; i++) begin
            rv = $urandom;
            do_load(rv[15:0], '0, 1'b0, 1'b1, w);
            if (rv[16]) load_valid = 1'b0;
            plane_ready = ($urandom % 4) != 0;
        end
        load_valid = 1'b0;
        drain(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
